// File: rtl/dma_channel_if.sv
// dma_channel_if: pipelined CPU memory bus shared by the DMA initiator and
// the memory responders, plus the req/gnt pair towards the bus arbiter.
//   addr/size/write : address phase, driven by the master (cycle N)
//   wdata           : write data, driven by the master in cycle N+1
//   rdata           : read data, driven by the responder in cycle N+1
//   pause           : responder wait state, the current cycle repeats
//   abort           : responder bus error
//   bus_req/bus_gnt : arbitration handshake

`ifndef MEM_SIZE_WORD
`define MEM_SIZE_BYTE 2'b00
`define MEM_SIZE_HALF 2'b01
`define MEM_SIZE_WORD 2'b10
`endif

interface dma_channel_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  size;
    logic        write;
    logic        pause;
    logic        abort;
    logic        bus_req;
    logic        bus_gnt;

    modport master (
        output addr, wdata, size, write, bus_req,
        input  rdata, pause, abort, bus_gnt
    );

    modport slave (
        input  addr, wdata, size, write, bus_req,
        output rdata, pause, abort, bus_gnt
    );
endinterface

// File: rtl/dma_channel.sv
// dma_channel: single-channel block-copy DMA initiator (one GBA DMA channel).
// Reads a unit from the source, writes it to the destination, repeats until
// the count is exhausted. All bus outputs are registered.
//   clk, rst_n      : clock, synchronous active-low reset
//   start           : pulse that latches the config below (ignored while busy)
//   src_addr/dst_addr/count/word_size/src_ctl/dst_ctl : transfer config
//   busy/done/err   : status (done is a pulse, err is sticky until next start)
//   bus             : master side of the memory bus and arbiter handshake

`ifndef MEM_SIZE_WORD
`define MEM_SIZE_BYTE 2'b00
`define MEM_SIZE_HALF 2'b01
`define MEM_SIZE_WORD 2'b10
`endif

module dma_channel #(
    parameter int CNT_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [CNT_W-1:0] count,
    input  logic             word_size,
    input  logic [1:0]       src_ctl,
    input  logic [1:0]       dst_ctl,
    output logic             busy,
    output logic             done,
    output logic             err,
    dma_channel_if.master    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD,
        S_WR,
        S_DRAIN,
        S_DONE
    } state_t;

    // Remaining count is one bit wider so that a zero count can hold 2**CNT_W.
    localparam logic [CNT_W:0] REM_ONE = (CNT_W+1)'(1);
    localparam logic [CNT_W:0] REM_MAX = {1'b1, {CNT_W{1'b0}}};

    state_t         state_q, state_d;
    logic [31:0]    src_q, src_d, dst_q, dst_d;
    logic [CNT_W:0] rem_q, rem_d;
    logic           word_q, word_d;
    logic [1:0]     sctl_q, sctl_d, dctl_q, dctl_d;
    logic [31:0]    addr_q, addr_d, wdata_q, wdata_d;
    logic [1:0]     size_q, size_d;
    logic           write_q, write_d, req_q, req_d;
    logic           busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [31:0]    src_step, dst_step, rd_unit;
    logic           abort_hit;

    // Next address: 1 = decrement, 2 = fixed, 0/3 = increment; wraps mod 2**32.
    function automatic logic [31:0] step_addr(input logic [31:0] a,
                                              input logic [1:0] ctl,
                                              input logic w);
        logic [31:0] inc;
        inc = w ? 32'd4 : 32'd2;
        case (ctl)
            2'd1:    return a - inc;
            2'd2:    return a;
            default: return a + inc;
        endcase
    endfunction

    function automatic logic [31:0] align(input logic [31:0] a, input logic w);
        return w ? {a[31:2], 2'b00} : {a[31:1], 1'b0};
    endfunction

    assign src_step  = step_addr(src_q, sctl_q, word_q);
    assign dst_step  = step_addr(dst_q, dctl_q, word_q);
    assign abort_hit = bus.abort && (state_q == S_RD || state_q == S_WR || state_q == S_DRAIN);

    // Halfword reads pick the lane addressed by src[1] and replicate it so the
    // write lands correctly whichever lane the destination halfword sits in.
    always_comb begin
        rd_unit = bus.rdata;
        if (!word_q)
            rd_unit = src_q[1] ? {bus.rdata[31:16], bus.rdata[31:16]}
                               : {bus.rdata[15:0],  bus.rdata[15:0]};
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        word_d  = word_q;
        sctl_d  = sctl_q;
        dctl_d  = dctl_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        write_d = write_q;
        req_d   = req_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        // A wait state freezes everything, including a start seen while idle.
        if (!bus.pause) begin
            if (abort_hit) begin
                // Pending write is dropped: write goes low and we finish at once.
                state_d = S_DONE;
                err_d   = 1'b1;
                write_d = 1'b0;
                req_d   = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_d = S_REQ;
                            src_d   = align(src_addr, word_size);
                            dst_d   = align(dst_addr, word_size);
                            rem_d   = (count == '0) ? REM_MAX : {1'b0, count};
                            word_d  = word_size;
                            sctl_d  = src_ctl;
                            dctl_d  = dst_ctl;
                            size_d  = word_size ? `MEM_SIZE_WORD : `MEM_SIZE_HALF;
                            err_d   = 1'b0;
                            req_d   = 1'b1;
                            busy_d  = 1'b1;
                        end
                    end
                    S_REQ: begin
                        // Grant is only looked at here; the bus is kept until DONE.
                        if (bus.bus_gnt) begin
                            state_d = S_RD;
                            addr_d  = src_q;
                            write_d = 1'b0;
                        end
                    end
                    S_RD: begin
                        state_d = S_WR;
                        addr_d  = dst_q;
                        write_d = 1'b1;
                    end
                    S_WR: begin
                        wdata_d = rd_unit;
                        src_d   = src_step;
                        dst_d   = dst_step;
                        rem_d   = rem_q - REM_ONE;
                        write_d = 1'b0;
                        if (rem_q == REM_ONE) begin
                            state_d = S_DRAIN;          // addr keeps the last dst
                        end else begin
                            state_d = S_RD;
                            addr_d  = src_step;
                        end
                    end
                    S_DRAIN: begin
                        state_d = S_DONE;
                        req_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                    S_DONE: begin
                        state_d = S_IDLE;
                        done_d  = 1'b0;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            word_q  <= 1'b1;
            sctl_q  <= '0;
            dctl_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= `MEM_SIZE_WORD;
            write_q <= 1'b0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            word_q  <= word_d;
            sctl_q  <= sctl_d;
            dctl_q  <= dctl_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            write_q <= write_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.addr    = addr_q;
    assign bus.wdata   = wdata_q;
    assign bus.size    = size_q;
    assign bus.write   = write_q;
    assign bus.bus_req = req_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_dma_channel.sv
// tb_dma_channel: directed bench for dma_channel with a small pipelined
// memory responder; expected values are hand-computed constants.

`ifndef MEM_SIZE_WORD
`define MEM_SIZE_BYTE 2'b00
`define MEM_SIZE_HALF 2'b01
`define MEM_SIZE_WORD 2'b10
`endif

module tb_dma_channel;
    localparam int CNT_W = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, start, word_size;
    logic [31:0]      src_addr, dst_addr;
    logic [CNT_W-1:0] count;
    logic [1:0]       src_ctl, dst_ctl;
    logic             busy, done, err;

    dma_channel_if bus();

    dma_channel #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .count(count),
        .word_size(word_size), .src_ctl(src_ctl), .dst_ctl(dst_ctl),
        .busy(busy), .done(done), .err(err), .bus(bus)
    );

    // ---------------- memory responder ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  sz;
    } wr_t;

    logic [31:0] mem_d [65536];
    logic [31:0] mem_t [65536];
    bit          mem_v [65536];
    wr_t         wlog[$];
    logic [31:0] rd_log[$];

    logic        pl_we;
    logic [31:0] pl_addr, pl_data;
    logic        wr_pend = 1'b0;
    logic [31:0] wr_a = '0;
    logic [1:0]  wr_sz = '0;
    logic [31:0] prev_addr = '0;

    function automatic logic [15:0] midx(input logic [31:0] a);
        return {a[25:24], a[15:2]};
    endfunction

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (mem_v[midx(a)] && mem_t[midx(a)] == wa) return mem_d[midx(a)];
        return pat(wa);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] wd,
                                          input logic [31:0] a, input logic [1:0] sz);
        if (sz != `MEM_SIZE_HALF) return wd;
        return a[1] ? {wd[31:16], cur[15:0]} : {cur[31:16], wd[15:0]};
    endfunction

    always @(posedge clk) begin
        if (pl_we) begin
            mem_d[midx(pl_addr)] <= pl_data;
            mem_t[midx(pl_addr)] <= {pl_addr[31:2], 2'b00};
            mem_v[midx(pl_addr)] <= 1'b1;
        end
        if (!bus.pause) begin
            if (wr_pend && !bus.abort) begin
                mem_d[midx(wr_a)] <= merge(rd_mem(wr_a), bus.wdata, wr_a, wr_sz);
                mem_t[midx(wr_a)] <= {wr_a[31:2], 2'b00};
                mem_v[midx(wr_a)] <= 1'b1;
                wlog.push_back('{wr_a, bus.wdata, wr_sz});
            end
            wr_pend   <= bus.write && !bus.abort;
            wr_a      <= bus.addr;
            wr_sz     <= bus.size;
            bus.rdata <= rd_mem(bus.addr);
            if (bus.write) rd_log.push_back(prev_addr);
            prev_addr <= bus.addr;
        end
    end

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Per-cycle observations of the most recent job (cycle 0 = start cycle).
    logic [31:0] obs_addr [64];
    logic        obs_write[64];
    logic        obs_req  [64];
    logic        obs_busy [64];
    logic        obs_err  [64];

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pl_addr = a;
        pl_data = d;
        pl_we   = 1'b1;
        @(negedge clk);
        pl_we   = 1'b0;
    endtask

    // Runs one job; schedule knobs are in cycles relative to the start cycle.
    // done_cyc = cycle done was seen, -1 on timeout, 0 when cut short by reset.
    task automatic run_job(input logic [31:0] s, input logic [31:0] d,
                           input logic [CNT_W-1:0] n, input logic ws,
                           input logic [1:0] sc, input logic [1:0] dc,
                           input int gnt_at, input int pause_at, input int abort_at,
                           input int restart_at, input int rst_at, input int limit,
                           output int done_cyc);
        int cyc;
        @(negedge clk);
        src_addr  = s;
        dst_addr  = d;
        count     = n;
        word_size = ws;
        src_ctl   = sc;
        dst_ctl   = dc;
        start     = 1'b1;
        bus.bus_gnt = (gnt_at <= 0);
        done_cyc  = -1;
        cyc       = 0;
        while (cyc < limit) begin
            @(negedge clk);
            cyc++;
            start       = (cyc == restart_at);
            src_addr    = (cyc == restart_at) ? 32'h0500_0000 : s;
            bus.bus_gnt = (cyc >= gnt_at);
            bus.pause   = (cyc >= pause_at) && (cyc < pause_at + 2);
            bus.abort   = (cyc == abort_at);
            rst_n       = (cyc != rst_at);
            if (cyc < 64) begin
                obs_addr[cyc]  = bus.addr;
                obs_write[cyc] = bus.write;
                obs_req[cyc]   = bus.bus_req;
                obs_busy[cyc]  = busy;
                obs_err[cyc]   = err;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (rst_at > 0 && cyc == rst_at + 1) begin
                done_cyc = 0;
                break;
            end
        end
        start       = 1'b0;
        bus.pause   = 1'b0;
        bus.abort   = 1'b0;
        bus.bus_gnt = 1'b1;
        rst_n       = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string t);
        chk({t, "_addr"},  bus.addr, 32'h0);
        chk({t, "_wdata"}, bus.wdata, 32'h0);
        chk({t, "_size"},  32'(bus.size), 32'(`MEM_SIZE_WORD));
        chk({t, "_write"}, 32'(bus.write), 32'h0);
        chk({t, "_req"},   32'(bus.bus_req), 32'h0);
        chk({t, "_busy"},  32'(busy), 32'h0);
        chk({t, "_done"},  32'(done), 32'h0);
        chk({t, "_err"},   32'(err), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, wb, rb;
        rst_n = 1'b0; start = 1'b0; word_size = 1'b1;
        src_addr = '0; dst_addr = '0; count = '0; src_ctl = '0; dst_ctl = '0;
        bus.bus_gnt = 1'b1; bus.pause = 1'b0; bus.abort = 1'b0;
        pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        rst_n = 1'b1;

        preload(32'h0300_0000, 32'h1111_1111);
        preload(32'h0300_0004, 32'h2222_2222);
        preload(32'h0300_0008, 32'h3333_3333);
        preload(32'h0200_0000, 32'hBEEF_1234);
        preload(32'h0200_0010, 32'hCAFE_5555);

        // Word copy inc/inc, count 3.
        run_job(32'h0300_0000, 32'h0300_0100, 3, 1'b1, 2'd0, 2'd0, 0, -10, -1, -1, -1, 100, dc);
        chk("t1_done_cyc", dc, 9);
        chk("t1_err", 32'(err), 0);
        chk("t1_w0", rd_mem(32'h0300_0100), 32'h1111_1111);
        chk("t1_w1", rd_mem(32'h0300_0104), 32'h2222_2222);
        chk("t1_w2", rd_mem(32'h0300_0108), 32'h3333_3333);

        // Halfword from the upper lane into a lower-lane destination.
        wb = wlog.size();
        run_job(32'h0200_0002, 32'h0200_0010, 1, 1'b0, 2'd0, 2'd0, 0, -10, -1, -1, -1, 100, dc);
        chk("t2_done_cyc", dc, 5);
        chk("t2_nwr", wlog.size() - wb, 1);
        if (wlog.size() > wb) begin
            chk("t2_addr", wlog[wb].a, 32'h0200_0010);
            chk("t2_size", 32'(wlog[wb].sz), 32'(`MEM_SIZE_HALF));
            chk("t2_wdata", wlog[wb].d, 32'hBEEF_BEEF);
        end
        chk("t2_mem", rd_mem(32'h0200_0010), 32'hCAFE_BEEF);

        // Decrementing source, fixed destination; a start mid-job must be ignored.
        wb = wlog.size();
        rb = rd_log.size();
        run_job(32'h0300_0008, 32'h0400_0000, 3, 1'b1, 2'd1, 2'd2, 0, -10, -1, 3, -1, 100, dc);
        chk("t3_done_cyc", dc, 9);
        chk("t3_nwr", wlog.size() - wb, 3);
        if (rd_log.size() >= rb + 3) begin
            chk("t3_rd0", rd_log[rb],     32'h0300_0008);
            chk("t3_rd1", rd_log[rb + 1], 32'h0300_0004);
            chk("t3_rd2", rd_log[rb + 2], 32'h0300_0000);
        end
        for (int i = 0; i < 3; i++)
            if (wlog.size() > wb + i) chk($sformatf("t3_wa%0d", i), wlog[wb + i].a, 32'h0400_0000);
        chk("t3_last", rd_mem(32'h0400_0000), 32'h1111_1111);

        // Grant delayed to cycle 6, pause over cycles 8-9 (first WR).
        run_job(32'h0300_0000, 32'h0300_0200, 3, 1'b1, 2'd0, 2'd0, 6, 8, -1, -1, -1, 100, dc);
        chk("t4_done_cyc", dc, 16);
        chk("t4_req_wait", 32'(obs_req[3]), 1);
        chk("t4_wr_pause", 32'(obs_write[9]), 1);
        chk("t4_addr_pause", obs_addr[9], 32'h0300_0200);
        chk("t4_w0", rd_mem(32'h0300_0200), 32'h1111_1111);
        chk("t4_w1", rd_mem(32'h0300_0204), 32'h2222_2222);
        chk("t4_w2", rd_mem(32'h0300_0208), 32'h3333_3333);

        // Abort during the second WR of a 4-unit copy.
        wb = wlog.size();
        run_job(32'h0300_0000, 32'h0300_0300, 4, 1'b1, 2'd0, 2'd0, 0, -10, 5, -1, -1, 100, dc);
        chk("t5_done_cyc", dc, 6);
        chk("t5_err", 32'(err), 1);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_nwr", wlog.size() - wb, 1);
        chk("t5_w0", rd_mem(32'h0300_0300), 32'h1111_1111);
        chk("t5_w1", rd_mem(32'h0300_0304), pat(32'h0300_0304));
        run_job(32'h0300_0004, 32'h0300_0304, 1, 1'b1, 2'd0, 2'd0, 0, -10, -1, -1, -1, 100, dc);
        chk("t5_err_clr", 32'(obs_err[1]), 0);
        chk("t5b_done_cyc", dc, 5);
        chk("t5b_w1", rd_mem(32'h0300_0304), 32'h2222_2222);

        // Reset mid-transfer, then a full 2**CNT_W word copy wrapping past 0.
        run_job(32'h0300_0000, 32'h0300_0400, 3, 1'b1, 2'd0, 2'd0, 0, -10, -1, -1, 4, 100, dc);
        chk_reset_outputs("t6_rst");
        wb = wlog.size();
        run_job(32'hFFFF_8001, 32'h0500_0003, 0, 1'b1, 2'd0, 2'd0, 0, -10, -1, -1, -1, 40000, dc);
        chk("t6_done_cyc", dc, 32771);
        chk("t6_nwr", wlog.size() - wb, 16384);
        chk("t6_first", rd_mem(32'h0500_0000), pat(32'hFFFF_8000));
        chk("t6_pre_wrap", rd_mem(32'h0500_7FFC), pat(32'hFFFF_FFFC));
        chk("t6_wrap", rd_mem(32'h0500_8000), pat(32'h0000_0000));
        chk("t6_last", rd_mem(32'h0500_FFFC), pat(32'h0000_7FFC));
        chk("t6_err", 32'(err), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/dma_channel.md
Name: dma_channel

Overview:
- Single-channel DMA bus initiator.
- Copies a block of halfwords or words from a source region to a destination region over the CPU memory bus (addr/wdata/rdata/size/write/pause/abort).
- It is the master side of the same pipelined bus that the simulation memories respond to. It is arbitrated against the ARM7TDMI-S core through a req/gnt pair.
- Models one GBA DMA channel. It is the first requester-side block for core-plus-DMA system simulation.

Parameters:
- CNT_W, 14, width of the transfer-count field. A count of 0 means 2**CNT_W units.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  one-cycle pulse that latches the config and begins a transfer; ignored while busy
- src_addr  input  32  source start address
- dst_addr  input  32  destination start address
- count  input  CNT_W  number of units to transfer
- word_size  input  1  1 = 32-bit units, 0 = 16-bit units
- src_ctl  input  2  source step: 0 = increment, 1 = decrement, 2 = fixed, 3 = treated as increment
- dst_ctl  input  2  destination step, same encoding as src_ctl
- busy  output  1  high from the cycle after start until the done cycle
- done  output  1  one-cycle pulse at completion or abort
- err  output  1  sticky abort flag; cleared by the next accepted start
- bus_req  output  1  bus request to the arbiter
- bus_gnt  input  1  bus grant from the arbiter
- pause  input  1  wait-state stall; freezes all state and outputs
- abort  input  1  bus error from the responder
- addr  output  32  bus address
- wdata  output  32  write data, driven one cycle after the write address
- rdata  input  32  read data, valid the cycle after the read address
- size  output  2  `MEM_SIZE_HALF or `MEM_SIZE_WORD
- write  output  1  write strobe for the address phase

Behaviour:
- Reset (rst_n low at posedge): state IDLE.
  - Outputs: addr=0, wdata=0, size=`MEM_SIZE_WORD, write=0, bus_req=0, busy=0, done=0, err=0.
  - Reset mid-transfer abandons the transfer immediately.
- Bus protocol: the address phase (addr/size/write) is in cycle N. Write data and read data both belong to cycle N+1.
- pause=1: no state, counter, address or output register changes, and rdata is not sampled. The cycle repeats once pause falls.
- Accepting start (IDLE only):
  - Latch src, dst, count (0 becomes 2**CNT_W), size and controls.
  - Force alignment: clear bit 0 for halfword units, bits 1:0 for word units.
  - Clear err.
- Step: 2 for halfword, 4 for word. Decrement subtracts the step; fixed leaves the address unchanged. Addresses wrap modulo 2**32.
- State machine:
  - IDLE: on start, go to REQ and set busy=1.
  - REQ: bus_req=1. When bus_gnt=1, go to RD; otherwise stay. Once granted, the bus is held until DONE, and gnt is not re-sampled.
  - RD: addr=src, write=0. wdata = data latched from the previous WR (don't-care on the first RD). Go to WR.
  - WR: addr=dst, write=1.
    - Latch rdata: word units take it whole. Halfword units take rdata[31:16] if src[1]=1, else rdata[15:0], replicated into both halves.
    - Step src and dst, decrement remaining.
    - If remaining becomes 0, go to DRAIN; else go to RD.
  - DRAIN: addr holds the last dst, write=0, wdata=latched data. Go to DONE.
  - DONE: done=1, busy=0, bus_req=0. Go to IDLE.
- Timing: with gnt already high and no pause, start at cycle 0 gives REQ at 1, first RD at 2, last WR at 2N+1, DRAIN at 2N+2, and done at 2N+3.
- abort=1 in any unpaused RD/WR/DRAIN cycle:
  - Set err=1, force write=0 on the next cycle, and go to DONE.
  - The write whose data phase was pending is dropped.
- start during busy: ignored; the latched config is unchanged.
- bus_gnt deasserting after the grant is taken: no effect.

Test Plan:
- Word copy, inc/inc, count=3, src=0x0300_0000 preloaded with 11111111/22222222/33333333, dst=0x0300_0100, gnt tied high -> dst words match the source; done pulses at cycle 9 after start; err=0.
- Halfword, src=0x0200_0002 holding 0xBEEF in the upper lane, count=1 -> write at 0x0200_0010 with size=`MEM_SIZE_HALF and wdata=0xBEEFBEEF; memory upper half unchanged and lower half = BEEF.
- Decrement/fixed: src_ctl=1 from 0x0300_0008, dst_ctl=2 at 0x0400_0000, word, count=3 -> reads at 08, 04, 00; all writes go to 0x0400_0000; last value written = word at 0x0300_0000.
- Grant delayed 5 cycles plus pause asserted 2 cycles during a WR -> bus_req held until gnt; WR addr/write held through the pause; final memory contents unchanged from the no-stall run; completion is 7 cycles later.
- abort pulsed during the 2nd WR of a count=4 copy -> err=1, done pulses, only the first word is written, busy=0; a new start then clears err.
- rst_n low in the middle of a transfer, then count=0 start with word units -> all outputs return to reset values; 16384 units are transferred; the address wraps correctly past the start of the region.
